// File: rtl/fmul_share_arb_if.sv
// rtl/fmul_share_arb_if.sv - requester, multiplier and response signals of the shared FP multiplier
interface fmul_share_arb_if #(
  parameter int NREQ = 4,
  parameter int IDW  = 3
);
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [32*NREQ-1:0] req_a;
  logic [32*NREQ-1:0] req_b;
  logic [31:0]        mul_a;
  logic [31:0]        mul_b;
  logic [31:0]        mul_f;
  logic               rsp_valid;
  logic               rsp_ready;
  logic [31:0]        rsp_data;
  logic [IDW-1:0]     rsp_id;
  logic               busy;

  modport slave (
    input  req_valid, req_a, req_b, mul_f, rsp_ready,
    output req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );

  modport master (
    output req_valid, req_a, req_b, mul_f, rsp_ready,
    input  req_ready, mul_a, mul_b, rsp_valid, rsp_data, rsp_id, busy
  );
endinterface

// File: rtl/fmul_share_arb.sv
// rtl/fmul_share_arb.sv - round-robin, credit-limited sharing of one pipelined FP multiplier
module fmul_share_arb #(
  parameter int NREQ       = 4,
  parameter int LAT        = 4,
  parameter int FIFO_DEPTH = 8,
  parameter int IDW        = 3
) (
  input  logic             clk,
  input  logic             rst,
  fmul_share_arb_if.slave  bus
);
  // Stage 0 sits beside the operand register; the last stage lines up with mul_f.
  localparam int NST = LAT + 1;
  localparam int PW  = $clog2(FIFO_DEPTH);
  localparam int CW  = PW + 1;

  logic [IDW-1:0]  rr_q, rr_d;
  logic [31:0]     mul_a_q, mul_b_q;
  logic [NST-1:0]  vld_q;
  logic [IDW-1:0]  id_q [NST];
  logic [IDW+31:0] mem_q [FIFO_DEPTH];
  logic [PW-1:0]   wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]   cnt_q;

  logic [15:0]     inflight, outstanding;
  logic            credit_ok;
  logic            gnt_vld;
  logic [IDW-1:0]  gnt_id;
  logic [NREQ-1:0] ready;
  logic [31:0]     sel_a, sel_b;
  logic            push, pop;

  // A pop this cycle is deliberately not counted as returned credit.
  always_comb begin
    inflight = '0;
    for (int s = 0; s < NST; s++) begin
      inflight = inflight + 16'(vld_q[s]);
    end
    outstanding = inflight + 16'(cnt_q);
    credit_ok   = outstanding < 16'(FIFO_DEPTH);
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_id  = '0;
    for (int k = 0; k < NREQ; k++) begin
      for (int i = 0; i < NREQ; i++) begin
        if (!gnt_vld && rst && credit_ok && bus.req_valid[i] &&
            (((int'(rr_q) + k) % NREQ) == i)) begin
          gnt_vld = 1'b1;
          gnt_id  = IDW'(i);
        end
      end
    end
  end

  always_comb begin
    ready = '0;
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (gnt_vld && (gnt_id == IDW'(i))) begin
        ready[i] = 1'b1;
        sel_a    = bus.req_a[32*i +: 32];
        sel_b    = bus.req_b[32*i +: 32];
      end
    end
  end

  always_comb begin
    rr_d = rr_q;
    if (gnt_vld) begin
      rr_d = (gnt_id == IDW'(NREQ - 1)) ? '0 : gnt_id + IDW'(1);
    end
  end

  assign push = vld_q[NST-1];
  assign pop  = (cnt_q != '0) && bus.rsp_ready;

  always_ff @(posedge clk) begin
    if (!rst) begin
      rr_q     <= '0;
      mul_a_q  <= '0;
      mul_b_q  <= '0;
      vld_q    <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      rr_q  <= rr_d;
      vld_q <= {vld_q[NST-2:0], gnt_vld};
      if (gnt_vld) begin
        mul_a_q <= sel_a;
        mul_b_q <= sel_b;
      end
      if (push) wr_ptr_q <= wr_ptr_q + PW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + PW'(1);
      case ({push, pop})
        2'b10:   cnt_q <= cnt_q + CW'(1);
        2'b01:   cnt_q <= cnt_q - CW'(1);
        default: cnt_q <= cnt_q;
      endcase
    end
  end

  // Payload-only state: qualified by vld_q / cnt_q, so it needs no reset.
  always_ff @(posedge clk) begin
    id_q[0] <= gnt_id;
    for (int s = 1; s < NST; s++) begin
      id_q[s] <= id_q[s-1];
    end
    if (push) mem_q[wr_ptr_q] <= {id_q[NST-1], bus.mul_f};
  end

  assign bus.req_ready = ready;
  assign bus.mul_a     = mul_a_q;
  assign bus.mul_b     = mul_b_q;
  assign bus.rsp_valid = cnt_q != '0;
  assign bus.rsp_data  = mem_q[rd_ptr_q][31:0];
  assign bus.rsp_id    = mem_q[rd_ptr_q][IDW+31:32];
  assign bus.busy      = (inflight != '0) || (cnt_q != '0);
endmodule

// File: tb/tb_fmul_share_arb.sv
// tb/tb_fmul_share_arb.sv - scoreboard bench for fmul_share_arb with an XOR stand-in multiplier
module tb_fmul_share_arb;
  localparam int NREQ = 4, LAT = 4, FIFO_DEPTH = 8, IDW = 3;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fmul_share_arb_if #(.NREQ(NREQ), .IDW(IDW)) bus();

  fmul_share_arb #(.NREQ(NREQ), .LAT(LAT), .FIFO_DEPTH(FIFO_DEPTH), .IDW(IDW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  logic [31:0] mpipe [LAT];
  always @(posedge clk) begin
    mpipe[0] <= bus.mul_a ^ bus.mul_b;
    for (int s = 1; s < LAT; s++) mpipe[s] <= mpipe[s-1];
  end
  assign bus.mul_f = mpipe[LAT-1];

  logic [31:0] tab_a [8] = '{32'h3FC00000, 32'h12345678, 32'hFFFFFFFF, 32'hAAAAAAAA,
                             32'hDEADBEEF, 32'h80000000, 32'hC0490FDB, 32'h01234567};
  logic [31:0] tab_b [8] = '{32'h40000000, 32'h0F0F0F0F, 32'h00000001, 32'h55555555,
                             32'h00000000, 32'h3F800000, 32'hC0490FDB, 32'h89ABCDEF};
  logic [31:0] tab_x [8] = '{32'h7FC00000, 32'h1D3B5977, 32'hFFFFFFFE, 32'hFFFFFFFF,
                             32'hDEADBEEF, 32'hBF800000, 32'h00000000, 32'h88888888};

  int cur_v [NREQ];
  int n_checks = 0, n_fail = 0, n_issue = 0, n_rsp = 0, out_cnt = 0, m_rr = 0;
  logic [IDW+31:0] exp_q [$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic apply_ops();
    for (int i = 0; i < NREQ; i++) begin
      bus.req_a[32*i +: 32] = tab_a[cur_v[i]];
      bus.req_b[32*i +: 32] = tab_b[cur_v[i]];
    end
  endtask

  // Reference arbiter/credit model; predicts the grant and queues the expected result.
  task automatic cycle();
    int g;
    logic [NREQ-1:0] exp_rdy;
    @(negedge clk);
    g = -1;
    exp_rdy = '0;
    if (!rst) begin
      m_rr = 0;
      out_cnt = 0;
      exp_q.delete();
    end else begin
      if (out_cnt < FIFO_DEPTH) begin
        for (int k = 0; k < NREQ; k++) begin
          if (g < 0 && bus.req_valid[(m_rr + k) % NREQ]) g = (m_rr + k) % NREQ;
        end
      end
      if (g >= 0) exp_rdy[g] = 1'b1;
      if (bus.rsp_valid && bus.rsp_ready) out_cnt--;
    end
    check("req_ready", 64'(bus.req_ready), 64'(exp_rdy));
    if (g >= 0) begin
      exp_q.push_back({IDW'(g), tab_x[cur_v[g]]});
      out_cnt++;
      n_issue++;
      m_rr = (g + 1) % NREQ;
    end
    @(posedge clk);
    #1;
    if (g >= 0) begin
      cur_v[g] = (cur_v[g] + 1) % 8;
      apply_ops();
    end
  endtask

  task automatic drain();
    logic done;
    bus.req_valid = '0;
    bus.rsp_ready = 1'b1;
    done = 1'b0;
    for (int k = 0; k < 100 && !done; k++) begin
      if (!bus.busy && exp_q.size() == 0) done = 1'b1;
      else cycle();
    end
    check("drain_done", 64'(done), 64'(1));
  endtask

  initial begin
    forever begin
      @(negedge clk);
      if (rst && bus.rsp_valid && bus.rsp_ready) begin
        logic [IDW+31:0] e;
        n_rsp++;
        if (exp_q.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("FAIL rsp_unexpected actual id=%0d data=%0h required=none at %0t",
                   bus.rsp_id, bus.rsp_data, $time);
        end else begin
          e = exp_q.pop_front();
          check("rsp_data", 64'(bus.rsp_data), 64'(e[31:0]));
          check("rsp_id", 64'(bus.rsp_id), 64'(e[IDW+31:32]));
        end
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int base, base_r, gaps;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < NREQ; i++) cur_v[i] = i;
    apply_ops();

    // Reset held with every requester asking
    rst = 1'b0;
    bus.req_valid = '1;
    cycle();
    cycle();
    check("reset_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("reset_busy", 64'(bus.busy), 64'(0));
    check("reset_req_ready", 64'(bus.req_ready), 64'(0));
    rst = 1'b1;
    cycle();
    check("first_grant_count", 64'(n_issue), 64'(1));
    drain();

    // Single op latency from requester 2
    cur_v[2] = 0;
    apply_ops();
    bus.req_valid = 4'b0100;
    bus.rsp_ready = 1'b0;
    cycle();
    bus.req_valid = '0;
    check("single_issue", 64'(n_issue), 64'(2));
    for (int e = 1; e <= 5; e++) begin
      cycle();
      if (e == 4) check("single_lat_early", 64'(bus.rsp_valid), 64'(0));
      if (e == 5) begin
        check("single_lat_valid", 64'(bus.rsp_valid), 64'(1));
        check("single_data", 64'(bus.rsp_data), 64'h7FC00000);
        check("single_id", 64'(bus.rsp_id), 64'(2));
      end
    end
    drain();

    // Round robin at full rate with no response gaps
    base = n_issue;
    gaps = 0;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < 24; i++) begin
      cycle();
      if (i >= 5 && !bus.rsp_valid) gaps++;
    end
    check("rr_issue_rate", 64'(n_issue - base), 64'(24));
    check("rr_rsp_gaps", 64'(gaps), 64'(0));
    drain();

    // Credit limit under back-pressure
    base = n_issue;
    bus.req_valid = '1;
    bus.rsp_ready = 1'b0;
    for (int i = 0; i < 20; i++) cycle();
    check("credit_issued", 64'(n_issue - base), 64'(FIFO_DEPTH));
    check("credit_ready_low", 64'(bus.req_ready), 64'(0));
    check("credit_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    base_r = n_rsp;
    drain();
    check("credit_drained", 64'(n_rsp - base_r), 64'(FIFO_DEPTH));
    base = n_issue;
    bus.req_valid = '1;
    cycle();
    check("credit_resume", 64'(n_issue - base), 64'(1));
    drain();

    // Simultaneous push/pop with toggling consumer
    base = n_issue;
    base_r = n_rsp;
    bus.req_valid = '1;
    for (int i = 0; i < 40; i++) begin
      bus.rsp_ready = i[0];
      cycle();
    end
    drain();
    check("toggle_all_returned", 64'(n_rsp - base_r), 64'(n_issue - base));

    // Reset with 3 ops in flight and 2 in the FIFO
    bus.rsp_ready = 1'b0;
    bus.req_valid = '1;
    for (int i = 0; i < 5; i++) cycle();
    bus.req_valid = '0;
    cycle();
    cycle();
    check("midop_busy", 64'(bus.busy), 64'(1));
    check("midop_rsp_valid", 64'(bus.rsp_valid), 64'(1));
    rst = 1'b0;
    cycle();
    check("midop_rst_rsp_valid", 64'(bus.rsp_valid), 64'(0));
    check("midop_rst_busy", 64'(bus.busy), 64'(0));
    rst = 1'b1;
    bus.rsp_ready = 1'b1;
    base_r = n_rsp;
    for (int i = 0; i < 20; i++) cycle();
    check("midop_no_stale", 64'(n_rsp - base_r), 64'(0));
    check("midop_idle_busy", 64'(bus.busy), 64'(0));

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
